// File: rtl/note_pkg.sv
// Shared constants, FSM state encoding and per-slot field slicing for the note spawner.
package note_pkg;

  localparam int unsigned NUM_SLOTS = 24;
  localparam int unsigned SLOT_W    = 5;
  localparam int unsigned TURN_W    = 4;

  localparam int unsigned TIMING_W  = 3;
  localparam int unsigned SPEED_W   = 3;
  localparam int unsigned DIR_W     = 2;
  localparam int unsigned INV_W     = 1;

  localparam int unsigned TIMING_BUS_W = NUM_SLOTS * TIMING_W;
  localparam int unsigned SPEED_BUS_W  = NUM_SLOTS * SPEED_W;
  localparam int unsigned DIR_BUS_W    = NUM_SLOTS * DIR_W;
  localparam int unsigned INV_BUS_W    = NUM_SLOTS * INV_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WAIT  = 3'd2,
    SPAWN = 3'd3,
    DONE  = 3'd4
  } state_e;

  function automatic logic [TIMING_W-1:0] timing_at(input logic [TIMING_BUS_W-1:0] bus,
                                                    input logic [SLOT_W-1:0] idx);
    return bus[TIMING_W * int'(idx) +: TIMING_W];
  endfunction

  function automatic logic [SPEED_W-1:0] speed_at(input logic [SPEED_BUS_W-1:0] bus,
                                                  input logic [SLOT_W-1:0] idx);
    return bus[SPEED_W * int'(idx) +: SPEED_W];
  endfunction

  function automatic logic [DIR_W-1:0] direction_at(input logic [DIR_BUS_W-1:0] bus,
                                                    input logic [SLOT_W-1:0] idx);
    return bus[DIR_W * int'(idx) +: DIR_W];
  endfunction

  function automatic logic [INV_W-1:0] inversed_at(input logic [INV_BUS_W-1:0] bus,
                                                   input logic [SLOT_W-1:0] idx);
    return bus[INV_W * int'(idx) +: INV_W];
  endfunction

endpackage

// File: rtl/note_spawner_slot_select.sv
// Combinational field mux: picks one slot's fields out of the latched pattern buses.
module slot_select
  import note_pkg::*;
(
  input  logic [TIMING_BUS_W-1:0] timing_in,
  input  logic [SPEED_BUS_W-1:0]  speed_in,
  input  logic [DIR_BUS_W-1:0]    direction_in,
  input  logic [INV_BUS_W-1:0]    inversed_in,
  input  logic [SLOT_W-1:0]       slot_in,
  output logic [TIMING_W-1:0]     timing_out,
  output logic [SPEED_W-1:0]      speed_out,
  output logic [DIR_W-1:0]        direction_out,
  output logic [INV_W-1:0]        inversed_out
);

  always_comb begin
    timing_out    = timing_at(timing_in, slot_in);
    speed_out     = speed_at(speed_in, slot_in);
    direction_out = direction_at(direction_in, slot_in);
    inversed_out  = inversed_at(inversed_in, slot_in);
  end

endmodule

// File: rtl/note_spawner.sv
// Plays one turn's note pattern: latches it, waits the programmed beats per slot and
// hands each note out over a valid/ready handshake, then advances the turn index.
module note_spawner
  import note_pkg::*;
#(
  parameter int unsigned       SLOTS     = NUM_SLOTS,
  parameter logic [TURN_W-1:0] LAST_TURN = 4'd15
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    start_in,
  input  logic                    beat_in,
  output logic [TURN_W-1:0]       turn_out,
  input  logic                    pattern_valid_in,
  input  logic [TIMING_BUS_W-1:0] timing_in,
  input  logic [SPEED_BUS_W-1:0]  speed_in,
  input  logic [DIR_BUS_W-1:0]    direction_in,
  input  logic [INV_BUS_W-1:0]    inversed_in,
  output logic                    spawn_valid_out,
  input  logic                    spawn_ready_in,
  output logic [SLOT_W-1:0]       spawn_slot_out,
  output logic [SPEED_W-1:0]      spawn_speed_out,
  output logic [DIR_W-1:0]        spawn_direction_out,
  output logic [INV_W-1:0]        spawn_inversed_out,
  output logic                    busy_out,
  output logic                    turn_done_out,
  output logic                    error_out
);

  state_e                  state_q, state_d;
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic [TIMING_W-1:0]     count_q, count_d;
  logic [TIMING_BUS_W-1:0] timing_q, timing_d;
  logic [SPEED_BUS_W-1:0]  speed_q, speed_d;
  logic [DIR_BUS_W-1:0]    dir_q, dir_d;
  logic [INV_BUS_W-1:0]    inv_q, inv_d;
  logic [TURN_W-1:0]       turn_q, turn_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic [TIMING_W-1:0]     cur_timing;
  logic                    last_slot;
  logic [SLOT_W-1:0]       slot_next;

  slot_select u_slot_select (
    .timing_in     (timing_q),
    .speed_in      (speed_q),
    .direction_in  (dir_q),
    .inversed_in   (inv_q),
    .slot_in       (slot_q),
    .timing_out    (cur_timing),
    .speed_out     (spawn_speed_out),
    .direction_out (spawn_direction_out),
    .inversed_out  (spawn_inversed_out)
  );

  assign last_slot = (slot_q == SLOT_W'(SLOTS - 1));
  assign slot_next = slot_q + SLOT_W'(1);

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    count_d  = count_q;
    timing_d = timing_q;
    speed_d  = speed_q;
    dir_d    = dir_q;
    inv_d    = inv_q;
    turn_d   = turn_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_in) state_d = LOAD;
      end
      LOAD: begin
        if (pattern_valid_in) begin
          timing_d = timing_in;
          speed_d  = speed_in;
          dir_d    = direction_in;
          inv_d    = inversed_in;
          slot_d   = '0;
          count_d  = timing_at(timing_in, '0);
          state_d  = WAIT;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT: begin
        // Empty slots are skipped at one per cycle without consuming beats.
        if (cur_timing == '0) begin
          if (last_slot) begin
            state_d = DONE;
          end else begin
            slot_d  = slot_next;
            count_d = timing_at(timing_q, slot_next);
          end
        end else if (beat_in) begin
          if (count_q == TIMING_W'(1)) begin
            state_d = SPAWN;
            valid_d = 1'b1;
          end else begin
            count_d = count_q - TIMING_W'(1);
          end
        end
      end
      SPAWN: begin
        if (spawn_ready_in) begin
          valid_d = 1'b0;
          if (last_slot) begin
            state_d = DONE;
          end else begin
            slot_d  = slot_next;
            count_d = timing_at(timing_q, slot_next);
            state_d = WAIT;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase

    // Completion pulse and turn advance share the edge that enters DONE.
    if (state_d == DONE) begin
      done_d = 1'b1;
      turn_d = (turn_q == LAST_TURN) ? '0 : turn_q + TURN_W'(1);
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      slot_q   <= '0;
      count_q  <= '0;
      timing_q <= '0;
      speed_q  <= '0;
      dir_q    <= '0;
      inv_q    <= '0;
      turn_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      count_q  <= count_d;
      timing_q <= timing_d;
      speed_q  <= speed_d;
      dir_q    <= dir_d;
      inv_q    <= inv_d;
      turn_q   <= turn_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign turn_out        = turn_q;
  assign spawn_valid_out = valid_q;
  assign spawn_slot_out  = slot_q;
  assign busy_out        = busy_q;
  assign turn_done_out   = done_q;
  assign error_out       = err_q;

endmodule

// File: tb/tb_note_spawner.sv
// Randomized bench for note_spawner: a schedule model predicts every cycle's outputs.
module tb_note_spawner;

  localparam int MAXC = 2000;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        start_in;
  logic        beat_in;
  logic [3:0]  turn_out;
  logic        pattern_valid_in;
  logic [71:0] timing_in;
  logic [71:0] speed_in;
  logic [47:0] direction_in;
  logic [23:0] inversed_in;
  logic        spawn_valid_out;
  logic        spawn_ready_in;
  logic [4:0]  spawn_slot_out;
  logic [2:0]  spawn_speed_out;
  logic [1:0]  spawn_direction_out;
  logic        spawn_inversed_out;
  logic        busy_out;
  logic        turn_done_out;
  logic        error_out;

  int nvec = 0;
  int nerr = 0;
  logic [3:0] exp_turn = 4'd0;

  bit beat_a  [MAXC];
  bit ready_a [MAXC];
  bit ev      [MAXC];
  int es      [MAXC];
  bit ed      [MAXC];
  bit eb      [MAXC];

  note_spawner dut (
    .clk_in              (clk_in),
    .rst_n_in            (rst_n_in),
    .start_in            (start_in),
    .beat_in             (beat_in),
    .turn_out            (turn_out),
    .pattern_valid_in    (pattern_valid_in),
    .timing_in           (timing_in),
    .speed_in            (speed_in),
    .direction_in        (direction_in),
    .inversed_in         (inversed_in),
    .spawn_valid_out     (spawn_valid_out),
    .spawn_ready_in      (spawn_ready_in),
    .spawn_slot_out      (spawn_slot_out),
    .spawn_speed_out     (spawn_speed_out),
    .spawn_direction_out (spawn_direction_out),
    .spawn_inversed_out  (spawn_inversed_out),
    .busy_out            (busy_out),
    .turn_done_out       (turn_done_out),
    .error_out           (error_out)
  );

  always #5 clk_in = ~clk_in;

  // Plays one turn. beat_mode: 0 random, 1 every 10th cycle, 2 every cycle.
  // ready_mode: 0 random, 1 always high, 2 low until cycle 8.
  task automatic play_turn(input int beat_mode, input int ready_mode, input string tag);
    int t, c, a, n, tv, end_e;
    logic [3:0] nt;
    end_e = -1;
    for (int k = 0; k < MAXC; k++) begin
      case (beat_mode)
        1:       beat_a[k] = (k % 10) == 5;
        2:       beat_a[k] = 1'b1;
        default: beat_a[k] = ($urandom % 2) == 0;
      endcase
      case (ready_mode)
        1:       ready_a[k] = 1'b1;
        2:       ready_a[k] = (k >= 8);
        default: ready_a[k] = ($urandom % 2) == 0;
      endcase
      ev[k] = 1'b0; es[k] = 0; ed[k] = 1'b0; eb[k] = 1'b0;
    end
    // Schedule: slot i waits for its T-th beat from the first WAIT cycle, then holds until ready.
    t = 2;
    for (int i = 0; i < 24; i++) begin
      tv = int'(timing_in[3*i +: 3]);
      if (tv == 0) begin
        if (i == 23) end_e = t;
        t++;
      end else begin
        n = 0;
        c = t;
        while (c < MAXC - 1) begin
          if (beat_a[c]) begin
            n++;
            if (n == tv) break;
          end
          c++;
        end
        a = c + 1;
        while (a < MAXC - 1 && !ready_a[a]) a++;
        for (int e = c; e < a && e < MAXC; e++) begin
          ev[e] = 1'b1;
          es[e] = i;
        end
        t = a + 1;
        if (i == 23) end_e = a;
      end
    end
    nvec++;
    if (end_e < 0 || end_e > MAXC - 4) begin
      nerr++;
      $display("FAIL %s schedule_budget got=%0d required<%0d", tag, end_e, MAXC - 4);
      return;
    end
    for (int e = 0; e <= end_e; e++) eb[e] = 1'b1;
    ed[end_e] = 1'b1;
    nt = (exp_turn == 4'd15) ? 4'd0 : exp_turn + 4'd1;

    for (int k = 0; k <= end_e + 2; k++) begin
      start_in       = (k == 0);
      beat_in        = beat_a[k];
      spawn_ready_in = ready_a[k];
      @(posedge clk_in);
      #1;
      nvec++;
      if (spawn_valid_out !== ev[k]) begin
        nerr++;
        $display("FAIL %s valid k=%0d got=%0b exp=%0b", tag, k, spawn_valid_out, ev[k]);
      end
      if (ev[k]) begin
        nvec++;
        if (spawn_slot_out !== 5'(es[k]) || spawn_speed_out !== speed_in[3*es[k] +: 3] ||
            spawn_direction_out !== direction_in[2*es[k] +: 2] ||
            spawn_inversed_out !== inversed_in[es[k]]) begin
          nerr++;
          $display("FAIL %s fields k=%0d got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", tag, k,
                   spawn_slot_out, spawn_speed_out, spawn_direction_out, spawn_inversed_out,
                   es[k], speed_in[3*es[k] +: 3], direction_in[2*es[k] +: 2], inversed_in[es[k]]);
        end
      end
      nvec++;
      if (turn_done_out !== ed[k] || busy_out !== eb[k] || error_out !== 1'b0) begin
        nerr++;
        $display("FAIL %s done/busy/err k=%0d got=%0b%0b%0b exp=%0b%0b0", tag, k,
                 turn_done_out, busy_out, error_out, ed[k], eb[k]);
      end
      nvec++;
      if (turn_out !== ((k >= end_e) ? nt : exp_turn)) begin
        nerr++;
        $display("FAIL %s turn k=%0d got=%0d exp=%0d", tag, k, turn_out,
                 (k >= end_e) ? nt : exp_turn);
      end
    end
    start_in = 1'b0; beat_in = 1'b0; spawn_ready_in = 1'b0;
    exp_turn = nt;
  endtask

  task automatic random_pattern();
    for (int i = 0; i < 24; i++) begin
      timing_in[3*i +: 3]    = (($urandom % 4) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      speed_in[3*i +: 3]     = 3'($urandom);
      direction_in[2*i +: 2] = 2'($urandom);
      inversed_in[i]         = 1'($urandom);
    end
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    start_in = 1'b0; beat_in = 1'b0; spawn_ready_in = 1'b0; pattern_valid_in = 1'b1;
    timing_in = '0; speed_in = '0; direction_in = '0; inversed_in = '0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in) rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
    nvec++;
    if ({turn_out, spawn_valid_out, busy_out, turn_done_out, error_out, spawn_slot_out} !== '0) begin
      nerr++;
      $display("FAIL reset_state got=%0h exp=0",
               {turn_out, spawn_valid_out, busy_out, turn_done_out, error_out, spawn_slot_out});
    end
  endtask

  task automatic test_normal();
    for (int i = 0; i < 24; i++) begin
      timing_in[3*i +: 3] = 3'd1;
      speed_in[3*i +: 3] = 3'd5;
      direction_in[2*i +: 2] = 2'd2;
      inversed_in[i] = 1'b0;
    end
    play_turn(1, 1, "normal");
  endtask

  task automatic test_skip();
    random_pattern();
    for (int i = 0; i < 23; i++) timing_in[3*i +: 3] = 3'd0;
    timing_in[69 +: 3] = 3'd2;
    play_turn(0, 1, "skip");
  endtask

  task automatic test_backpressure();
    random_pattern();
    timing_in[0 +: 3] = 3'd1;
    timing_in[3 +: 3] = 3'd3;
    play_turn(2, 2, "backpressure");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      random_pattern();
      play_turn(0, 0, "random");
    end
  endtask

  task automatic test_invalid();
    pattern_valid_in = 1'b0;
    start_in = 1'b1;
    @(posedge clk_in);
    #1;
    start_in = 1'b0;
    nvec++;
    if (busy_out !== 1'b1 || error_out !== 1'b0) begin
      nerr++;
      $display("FAIL invalid_load busy/err got=%0b%0b exp=10", busy_out, error_out);
    end
    @(posedge clk_in);
    #1;
    nvec++;
    if (error_out !== 1'b1 || busy_out !== 1'b0 || spawn_valid_out !== 1'b0 || turn_out !== exp_turn) begin
      nerr++;
      $display("FAIL invalid_err err/busy/valid/turn got=%0b%0b%0b/%0d exp=100/%0d",
               error_out, busy_out, spawn_valid_out, turn_out, exp_turn);
    end
    @(posedge clk_in);
    #1;
    nvec++;
    if (error_out !== 1'b0 || busy_out !== 1'b0) begin
      nerr++;
      $display("FAIL invalid_pulse err/busy got=%0b%0b exp=00", error_out, busy_out);
    end
    pattern_valid_in = 1'b1;
  endtask

  task automatic test_wrap();
    int guard;
    guard = 0;
    timing_in = '0;
    while (exp_turn != 4'd15 && guard < 20) begin
      play_turn(0, 0, "wrap_fill");
      guard++;
    end
    random_pattern();
    play_turn(0, 1, "wrap");
    nvec++;
    if (turn_out !== 4'd0) begin
      nerr++;
      $display("FAIL wrap_turn got=%0d exp=0", turn_out);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 24; i++) timing_in[3*i +: 3] = 3'd1;
    start_in = 1'b1; beat_in = 1'b1; spawn_ready_in = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(posedge clk_in);
      #1;
      start_in = 1'b0;
      spawn_ready_in = 1'b0;
      if (spawn_valid_out && spawn_slot_out == 5'd5) found = 1'b1;
      else if (spawn_valid_out) spawn_ready_in = 1'b1;
    end
    nvec++;
    if (!found) begin
      nerr++;
      $display("FAIL reset_mid_reach_slot5 got=%0d exp=5", spawn_slot_out);
    end
    #2 rst_n_in = 1'b0;
    #1;
    nvec++;
    if ({turn_out, spawn_valid_out, busy_out, turn_done_out, error_out, spawn_slot_out,
         spawn_speed_out, spawn_direction_out, spawn_inversed_out} !== '0) begin
      nerr++;
      $display("FAIL reset_mid_outputs got=%0h exp=0",
               {turn_out, spawn_valid_out, busy_out, turn_done_out, error_out, spawn_slot_out,
                spawn_speed_out, spawn_direction_out, spawn_inversed_out});
    end
    start_in = 1'b0; beat_in = 1'b0; spawn_ready_in = 1'b0;
    @(negedge clk_in) rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
    exp_turn = 4'd0;
    random_pattern();
    timing_in[0 +: 3] = 3'd1;
    play_turn(0, 0, "replay");
  endtask

  initial begin
    test_reset();
    test_normal();
    test_skip();
    test_backpressure();
    test_random();
    test_invalid();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/note_spawner.md
# note_spawner

Downstream consumer of the per-turn `pattern` lookup. It drives the turn index to the pattern blocks and latches the selected pattern. It then walks the 24 note slots in order, waiting the programmed number of beats before each one. For each slot it emits a spawn request with a valid/ready handshake. When all slots are finished it pulses completion and advances to the next turn.

## Interface
Parameters:
- `SLOTS`, 24: note slots per pattern.
- `LAST_TURN`, 4'd15: highest turn index; `turn_out` wraps to 0 after it.

Ports:
- `clk_in` input 1: system clock.
- `rst_n_in` input 1: reset; asynchronous, active-low.
- `start_in` input 1: one-cycle request to play the current turn; ignored unless IDLE.
- `beat_in` input 1: one-cycle beat tick.
- `turn_out` output 4: turn index driven to the pattern blocks' `turn_in`.
- `pattern_valid_in` input 1: OR of the pattern blocks' `valid_out`.
- `timing_in` input 72: 3 bits per slot; slot i = [3i+2:3i].
- `speed_in` input 72: 3 bits per slot.
- `direction_in` input 48: 2 bits per slot; slot i = [2i+1:2i].
- `inversed_in` input 24: 1 bit per slot.
- `spawn_valid_out` output 1: a spawn request is presented.
- `spawn_ready_in` input 1: the consumer accepts the request.
- `spawn_slot_out` output 5: slot index of the request.
- `spawn_speed_out` output 3, `spawn_direction_out` output 2, `spawn_inversed_out` output 1: the slot's fields.
- `busy_out` output 1: high in every state except IDLE.
- `turn_done_out` output 1: one-cycle pulse when a turn completes.
- `error_out` output 1: one-cycle pulse when LOAD sees `pattern_valid_in` = 0.

## Operation
- **IDLE:** when `start_in` = 1, go to LOAD.
- **LOAD** (one cycle):
  - If `pattern_valid_in` = 1: capture all four pattern buses into internal registers, set slot = 0, load beat count = timing[slot 0], go to WAIT.
  - Otherwise: pulse `error_out` and return to IDLE. `turn_out` is unchanged.
- **WAIT:**
  - If the current slot's timing = 0, the slot is empty. Advance one slot per cycle with no beat needed. If the empty slot is SLOTS-1, go to DONE.
  - Otherwise each `beat_in` decrements the count. A `beat_in` while the count = 1 moves to SPAWN.
- **SPAWN:**
  - Hold `spawn_valid_out` = 1 with the slot's fields stable until `spawn_ready_in` = 1 in the same cycle.
  - On acceptance: if slot = SLOTS-1, go to DONE; else increment slot, reload the count from the new slot's timing, go to WAIT.
  - `beat_in` pulses during SPAWN are discarded; they do not count toward the next slot.
- **DONE** (one cycle): pulse `turn_done_out`, set `turn_out` = (`turn_out` = LAST_TURN) ? 0 : `turn_out`+1, go to IDLE.
- The patterns are combinational in `turn_out`, so `turn_out` must be stable from IDLE through LOAD. It changes only in DONE.
- Reset (any state, mid-turn included):
  - All outputs go to 0, `turn_out` = 0, state = IDLE.
  - Latched pattern, slot index and count are cleared.
  - A pending spawn is dropped with no acceptance.

## Timing
- `start_in` sampled at cycle N → LOAD at N+1 → WAIT at N+2.
- Slot with timing T ≥ 1: `spawn_valid_out` rises the cycle after the T-th `beat_in` sampled in WAIT.
- Empty slot: costs exactly one cycle.
- `spawn_ready_in` held high: the handshake completes in one cycle, and WAIT for the next slot starts the following cycle.
- After the accept of slot SLOTS-1 (or the skip of an empty last slot): `turn_done_out` asserts the next cycle, with `turn_out` updated in the same edge.
- `busy_out` falls together with the return to IDLE.
- `start_in` and `beat_in` arriving in the same cycle while IDLE: only the start takes effect.
- All outputs are registered; no combinational path from inputs to outputs except the field muxing of the latched registers by slot index.

## Structure
- `note_pkg` package holds:
  - the `SLOTS` default and the field widths (timing 3, speed 3, direction 2, inversed 1);
  - the state enum {IDLE, LOAD, WAIT, SPAWN, DONE};
  - slice functions returning slot i's fields from the packed buses.
- One combinational sub-module, `slot_select`: takes the latched buses and the slot index and returns that slot's timing, speed, direction and inversed.

## Test plan
- **Normal turn:** reset; pattern with all timing = 1, speed = 3'd5, direction = 2'd2, inversed = 0; `start_in`; one beat every 10 cycles; ready always high → 24 spawns with slots 0..23, fields 5/2/0, then `turn_done_out` and `turn_out` = 1.
- **Skip:** timing = 0 in slots 0–22, slot 23 timing = 2 → no spawn until the 2nd beat, then slot 23 spawns; 23 skip cycles only.
- **Backpressure:** ready low for 5 cycles during the slot-0 spawn, with beats arriving meanwhile → valid held and fields stable; the discarded beats are not counted toward slot 1.
- **Invalid pattern:** `pattern_valid_in` = 0 at LOAD → `error_out` pulse, state returns to IDLE, `turn_out` unchanged.
- **Wrap:** complete a turn at `turn_out` = 15 → `turn_out` = 0.
- **Reset mid-turn:** assert `rst_n_in` low during slot-5 SPAWN → all outputs 0 immediately; a later start replays from slot 0 at turn 0.
